// File: rtl/iob_pwm_mc.sv
// Multi-channel PWM on the native CPU bus, with double-buffered period and duty registers.
// Define PWM_PRESCALER_EN to add the PRESCALE register (address 3) and its tick prescaler.
module iob_pwm_mc #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [N_CH-1:0]     pwm_o,
    output logic                wrap_o
);

    localparam int NB = DATA_W / 8;

    logic             run;
    logic [N_CH-1:0]  en;
    logic [CNT_W-1:0] per_p;
    logic [CNT_W-1:0] per_a;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_p [N_CH];
    logic [CNT_W-1:0] duty_a [N_CH];
    logic             wrap_flag;
    logic             tick;
    logic             wrap;
    logic             wr;
    logic             rd_status;
    logic [DATA_W-1:0] rd_mux;

    // Byte-lane merge of write data into the current register contents.
    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [NB-1:0]     s);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < NB; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

`ifdef PWM_PRESCALER_EN
    logic [15:0] prescale;
    logic [15:0] pc;
    assign tick = (pc == prescale);
`else
    assign tick = 1'b1;
`endif

    assign wrap      = run & tick & (cnt == per_a);
    assign wr        = valid & (|wstrb);
    assign rd_status = valid & ~(|wstrb) & (addr == ADDR_W'(2));

    always_comb begin
        rd_mux = '0;
        if (addr == ADDR_W'(0)) rd_mux = DATA_W'({en, run});
        if (addr == ADDR_W'(1)) rd_mux = DATA_W'(per_p);
        if (addr == ADDR_W'(2)) rd_mux = DATA_W'(wrap_flag);
`ifdef PWM_PRESCALER_EN
        if (addr == ADDR_W'(3)) rd_mux = DATA_W'(prescale);
`endif
        for (int i = 0; i < N_CH; i++)
            if (addr == ADDR_W'(4 + i)) rd_mux = DATA_W'(duty_p[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            en        <= '0;
            per_p     <= '0;
            per_a     <= '0;
            cnt       <= '0;
            wrap_flag <= 1'b0;
            ready     <= 1'b0;
            rdata     <= '0;
            pwm_o     <= '0;
            wrap_o    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_p[i] <= '0;
                duty_a[i] <= '0;
            end
`ifdef PWM_PRESCALER_EN
            prescale <= '0;
            pc       <= '0;
`endif
        end else begin
            ready  <= valid;
            wrap_o <= wrap;
            if (valid) rdata <= rd_mux;

            // A wrap in the same cycle as a STATUS read keeps the flag set.
            if (wrap)           wrap_flag <= 1'b1;
            else if (rd_status) wrap_flag <= 1'b0;

            // Stopped: actives follow pendings so a fresh start uses the latest values.
            if (!run) begin
                cnt   <= '0;
                per_a <= per_p;
                for (int i = 0; i < N_CH; i++) duty_a[i] <= duty_p[i];
            end else if (tick) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
                if (wrap) begin
                    per_a <= per_p;
                    for (int i = 0; i < N_CH; i++) duty_a[i] <= duty_p[i];
                end
            end

            for (int i = 0; i < N_CH; i++)
                pwm_o[i] <= run & en[i] & (cnt < duty_a[i]);

`ifdef PWM_PRESCALER_EN
            if (!run || tick) pc <= '0;
            else              pc <= pc + 16'd1;
            if (wr && addr == ADDR_W'(3))
                prescale <= 16'(merge(DATA_W'(prescale), wdata, wstrb));
`endif

            if (wr && addr == ADDR_W'(0))
                {en, run} <= (N_CH+1)'(merge(DATA_W'({en, run}), wdata, wstrb));
            if (wr && addr == ADDR_W'(1))
                per_p <= CNT_W'(merge(DATA_W'(per_p), wdata, wstrb));
            for (int i = 0; i < N_CH; i++)
                if (wr && addr == ADDR_W'(4 + i))
                    duty_p[i] <= CNT_W'(merge(DATA_W'(duty_p[i]), wdata, wstrb));
        end
    end

endmodule

// File: tb/tb_iob_pwm_mc.sv
// Bench for iob_pwm_mc: directed scenarios plus random bus traffic against a behavioural model.
// Honours PWM_PRESCALER_EN the same way the design does.
module tb_iob_pwm_mc;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [3:0]        wstrb = '0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [N_CH-1:0]   pwm_o;
    logic              wrap_o;

    iob_pwm_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .pwm_o(pwm_o), .wrap_o(wrap_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hi [N_CH];
    int wraps;

    // reference model state
    logic             m_run;
    logic [N_CH-1:0]  m_en;
    logic [15:0]      m_pp, m_pa, m_cnt, m_ps, m_pc;
    logic [15:0]      m_pd [N_CH];
    logic [15:0]      m_da [N_CH];
    logic             m_sticky;
    logic [31:0]      m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'({m_en, m_run});
        if (a == 1) return 32'(m_pp);
        if (a == 2) return 32'(m_sticky);
`ifdef PWM_PRESCALER_EN
        if (a == 3) return 32'(m_ps);
`endif
        if (a >= 4 && a < 4 + N_CH) return 32'(m_pd[a-4]);
        return 32'd0;
    endfunction

    task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] t;
        if (a == 0) begin
            t = mrg(32'({m_en, m_run}), d, s);
            m_run = t[0];
            m_en  = t[N_CH:1];
        end else if (a == 1) begin
            t = mrg(32'(m_pp), d, s);
            m_pp = t[15:0];
`ifdef PWM_PRESCALER_EN
        end else if (a == 3) begin
            t = mrg(32'(m_ps), d, s);
            m_ps = t[15:0];
`endif
        end else if (a >= 4 && a < 4 + N_CH) begin
            t = mrg(32'(m_pd[a-4]), d, s);
            m_pd[a-4] = t[15:0];
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_en = '0; m_pp = 0; m_pa = 0; m_cnt = 0; m_ps = 0; m_pc = 0;
        m_sticky = 0; m_rdata = 0;
        for (int i = 0; i < N_CH; i++) begin m_pd[i] = 0; m_da[i] = 0; end
    endtask

    function automatic logic m_tick();
`ifdef PWM_PRESCALER_EN
        return m_pc == m_ps;
`else
        return 1'b1;
`endif
    endfunction

    // One clock edge: predict what the edge does, then sample the DUT 1 time unit later.
    task automatic step();
        logic            tk, wr_ev, exp_ready;
        logic [N_CH-1:0] epwm;
        @(posedge clk);
        exp_ready = valid;
        if (valid) m_rdata = m_read(int'(addr));
        tk    = m_tick();
        wr_ev = m_run && tk && (m_cnt == m_pa);
        for (int i = 0; i < N_CH; i++) epwm[i] = m_run && m_en[i] && (m_cnt < m_da[i]);
        if (!m_run) begin
            m_cnt = 0; m_pc = 0; m_pa = m_pp;
            for (int i = 0; i < N_CH; i++) m_da[i] = m_pd[i];
        end else begin
            m_pc = tk ? 16'd0 : m_pc + 16'd1;
            if (tk) m_cnt = wr_ev ? 16'd0 : m_cnt + 16'd1;
            if (wr_ev) begin
                m_pa = m_pp;
                for (int i = 0; i < N_CH; i++) m_da[i] = m_pd[i];
            end
        end
        m_sticky = wr_ev | (m_sticky & ~(valid && wstrb == 0 && addr == 2));
        if (valid && wstrb != 0) m_write(int'(addr), wdata, wstrb);
        #1;
        chk("ready", 32'(ready), 32'(exp_ready));
        chk("rdata", rdata, m_rdata);
        chk("pwm_o", 32'(pwm_o), 32'(epwm));
        chk("wrap_o", 32'(wrap_o), 32'(wr_ev));
        for (int i = 0; i < N_CH; i++) if (pwm_o[i]) hi[i]++;
        if (wrap_o) wraps++;
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N_CH; i++) hi[i] = 0;
        wraps = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic bus(input int a, input logic [31:0] d, input logic [3:0] s);
        valid = 1; addr = ADDR_W'(a); wdata = d; wstrb = s;
        step();
        valid = 0; wstrb = 0;
    endtask

    task automatic wait_wrap();
        logic seen = 0;
        for (int g = 0; g < 300 && !seen; g++) begin
            step();
            seen = wrap_o;
        end
        chk("wrap_seen", 32'(seen), 32'd1);
    endtask

    task automatic async_reset();
        #2 rst = 1;
        #1;
        chk("rst_pwm", 32'(pwm_o), 32'd0);
        chk("rst_wrap", 32'(wrap_o), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        m_reset();
        @(negedge clk) rst = 0;
    endtask

    initial begin
        logic seen;
        m_reset();
        clr_counts();
        #12 rst = 0;
        @(negedge clk);

        // reset values of every mapped address
        for (int a = 0; a < 4 + N_CH; a++) begin
            bus(a, 0, 0);
            chk("reset_read", rdata, 32'd0);
        end
        idle(2);

        // basic 3-of-10 waveform on channel 0
        bus(1, 9, 4'hF);
        bus(4, 3, 4'hF);
        bus(0, 3, 4'hF);
        clr_counts();
        idle(30);
        chk("ch0_high_30", 32'(hi[0]), 32'd9);
        chk("wraps_30", 32'(wraps), 32'd3);
        chk("ch1_3_low", 32'(hi[1] + hi[2] + hi[3]), 32'd0);

        // mid-period duty change waits for the boundary
        clr_counts();
        idle(2);
        bus(4, 7, 4'hF);
        wait_wrap();
        chk("old_duty_period", 32'(hi[0]), 32'd3);
        clr_counts();
        idle(10);
        chk("new_duty_period", 32'(hi[0]), 32'd7);

        // duty extremes on all channels
        bus(5, 0, 4'hF);
        bus(6, 10, 4'hF);
        bus(7, 9, 4'hF);
        bus(0, 32'h1F, 4'hF);
        wait_wrap();
        clr_counts();
        idle(10);
        chk("ch1_zero", 32'(hi[1]), 32'd0);
        chk("ch2_full", 32'(hi[2]), 32'd10);
        chk("ch3_nine", 32'(hi[3]), 32'd9);
        chk("one_wrap", 32'(wraps), 32'd1);

        // sticky WRAP and read-on-wrap
        bus(2, 0, 0);
        chk("status_set", rdata, 32'd1);
        bus(2, 0, 0);
        chk("status_clr", rdata, 32'd0);
        for (int g = 0; g < 40 && !(m_run && m_tick() && m_cnt == m_pa); g++) step();
        bus(2, 0, 0);
        chk("status_on_wrap", rdata, 32'd0);
        bus(2, 0, 0);
        chk("status_kept", rdata, 32'd1);

`ifdef PWM_PRESCALER_EN
        async_reset();
        bus(3, 3, 4'hF);
        bus(1, 4, 4'hF);
        bus(4, 2, 4'hF);
        bus(0, 3, 4'hF);
        wait_wrap();
        clr_counts();
        idle(20);
        chk("presc_high", 32'(hi[0]), 32'd8);
        chk("presc_wraps", 32'(wraps), 32'd1);
`else
        bus(3, 32'hFFFF_FFFF, 4'hF);
        bus(3, 0, 0);
        chk("presc_absent", rdata, 32'd0);
`endif

        // reset in the middle of a high phase
        seen = 0;
        for (int g = 0; g < 100 && !seen; g++) begin
            step();
            seen = pwm_o[0];
        end
        chk("pwm_high_seen", 32'(seen), 32'd1);
        async_reset();
        clr_counts();
        idle(12);
        chk("post_rst_low", 32'(hi[0] + wraps), 32'd0);
        bus(1, 4, 4'hF);
        bus(4, 2, 4'hF);
        bus(0, 3, 4'hF);
        idle(12);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            int op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: bus(4 + $urandom_range(0, N_CH-1), $urandom_range(0, 12),
                             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
                3: bus(1, $urandom_range(0, 10), 4'hF);
                4: bus(0, {$urandom_range(0, 15), ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0}, 4'hF);
                5, 6: bus($urandom_range(0, 15), 0, 0);
                7: idle($urandom_range(1, 5));
                8: bus(3, $urandom_range(0, 3), 4'hF);
                default: begin
                    int a = $urandom_range(0, 15);
                    logic [31:0] d = $urandom;
                    if (a == 1 || a == 3) d = d & 32'hF;
                    bus(a, d, 4'($urandom));
                end
            endcase
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iob_pwm_mc.md
Name: iob_pwm_mc

Overview:
- Multi-channel PWM peripheral; parametrised successor to the SoC's single-output PWM.
- N_CH independent duty channels share one CNT_W-bit period counter.
- Configured over the native CPU slave bus (valid/addr/wdata/wstrb/rdata/ready).
- Duty and period writes are double-buffered, so updates take effect glitch-free at the period boundary.

Parameters:
- N_CH, 4: number of PWM output channels (1..31).
- CNT_W, 16: counter, period and duty width (2..32).
- DATA_W, 32: bus data width.
- ADDR_W, 6: word-address width; must satisfy 2^ADDR_W >= 4+N_CH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  bus request.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes; all-zero means a read.
- rdata  out  DATA_W  read data.
- ready  out  1  request acknowledge.
- pwm_o  out  N_CH  PWM outputs, registered.
- wrap_o  out  1  one-cycle pulse at each period wrap.

Behaviour:
- Interface:
  - One clock domain (clk). Reset is asynchronous and active-high on rst.
  - All registers and outputs reset to 0: ready, rdata, pwm_o, wrap_o, counter, shadows and actives.
- Bus:
  - ready is asserted exactly 1 cycle after every valid cycle, including unmapped addresses. A valid on consecutive cycles gives ready on consecutive cycles.
  - rdata is valid with ready. rdata holds its value when ready is low.
  - Writes apply per byte lane using wstrb. Bits above a field's width are ignored on write and read as 0.
- Register map (word addresses):
  - 0 CTRL: bit0 RUN; bits N_CH:1 channel enables EN[i].
  - 1 PERIOD: pending period P, CNT_W bits.
  - 2 STATUS: bit0 WRAP, sticky; cleared by a read of STATUS. Read-only.
  - 3 PRESCALE: see Optional Feature; reads 0 when the feature is absent.
  - 4+i DUTY[i]: pending duty D[i], CNT_W bits.
  - Unmapped addresses: reads return 0; writes are ignored.
- Counter:
  - A tick is every clk cycle, or every prescaler expiry when the feature is enabled.
  - With RUN=1, on each tick: cnt <= (cnt==Pa) ? 0 : cnt+1.
  - With RUN=0: cnt is held at 0, no wraps occur, and the prescaler is held at 0.
- Wrap event:
  - Occurs on a tick with RUN=1 and cnt==Pa.
  - Effects: wrap_o pulses the next cycle; STATUS.WRAP is set; active Pa and Da[i] load from pending P and D[i].
  - If a pending register is written in the same cycle as a wrap, the old pending value loads; the new value waits for the next wrap.
- While RUN=0, actives track pendings every cycle (transparent). Changes to RUN and EN take effect immediately, not shadowed.
- Output: pwm_o[i] <= RUN & EN[i] & (cnt < Da[i]). The output is registered, i.e. 1 cycle behind cnt.
  - Da=0: output constantly low.
  - Da > Pa: output constantly high (100% duty).
  - Pa=0: counter stays 0 and wraps every tick. Output is high iff Da >= 1.
- STATUS.WRAP: if a wrap set and a STATUS read occur in the same cycle, set wins. The returned rdata reflects the value before that cycle.
- Comparisons are unsigned, full CNT_W wide, with no overflow. cnt never exceeds Pa because Pa changes only at wrap or when RUN=0.
- Reset mid-period: counter, outputs and all registers return to 0 asynchronously. The next period starts only after RUN is rewritten to 1.

Optional Feature:
- Macro: PWM_PRESCALER_EN.
- Defined:
  - Adds a 16-bit PRESCALE register at address 3 (reset 0) and a 16-bit prescaler counter pc.
  - A tick occurs when pc==PRESCALE, and pc then resets to 0; otherwise pc increments.
  - PRESCALE=0 gives a tick every cycle. PRESCALE=N gives a tick every N+1 cycles.
  - PRESCALE is not shadowed. If a write lowers PRESCALE below the current pc, pc continues to count up, wraps modulo 2^16, and then matches.
- Undefined: every cycle is a tick; address 3 reads 0 and ignores writes; no prescaler logic is instantiated.

Test Plan:
- Reset, then a read of each address 0..4+N_CH-1 -> rdata=0 for all; ready 1 cycle after each valid; pwm_o=0; wrap_o=0.
- PERIOD=9, DUTY0=3, CTRL=0x3 (RUN, EN0) -> pwm_o[0] is high 3 cycles and low 7 cycles, repeating every 10 cycles; wrap_o pulses every 10 cycles; pwm_o[3:1]=0.
- While running with Pa=9, write DUTY0=7 mid-period -> the current period keeps 3 high cycles; the first full period after the next wrap has 7 high cycles; no glitch.
- DUTY1=0, DUTY2=10, DUTY3=9 with PERIOD=9 and all channels enabled -> ch1 constantly low, ch2 constantly high, ch3 high 9 of 10 cycles.
- Let a wrap set STATUS.WRAP, then read STATUS -> rdata bit0=1, and a following read returns 0. Repeat with the read landing on a wrap cycle -> the flag remains set.
- With PWM_PRESCALER_EN: PRESCALE=3, PERIOD=4, DUTY0=2 -> period of 20 cycles with pwm_o[0] high for 8; assert rst mid-period -> pwm_o=0 immediately and remains 0 until RUN is rewritten.
